// File: rtl/adder_421_result_unloader.sv
// adder_421_result_unloader: captures wide adder sums and drains them LSB-beat first over valid/ready.
// One active shift register plus one pending word; words arriving with no space are dropped and counted.
module adder_421_result_unloader #(
   parameter int IN_WIDTH   = 1024,
   parameter int BEAT_WIDTH = 128,
   parameter int CNT_WIDTH  = 16,
   localparam int NUM_BEATS = IN_WIDTH / BEAT_WIDTH,
   localparam int IDX_W     = $clog2(NUM_BEATS)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_valid,
   input  logic [IN_WIDTH-1:0]   in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BEAT_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic [IDX_W-1:0]      out_index,
   output logic [CNT_WIDTH-1:0]  drop_cnt,
   output logic                  overflow
);
   logic [IN_WIDTH-1:0] act, act_n, pend, pend_n;
   logic                act_v, act_v_n, pend_v, pend_v_n, beat, fin, drop;
   logic [IDX_W-1:0]    idx_n;
   assign in_ready  = ~pend_v;
   assign out_valid = act_v;
   assign out_data  = act[BEAT_WIDTH-1:0];
   assign out_last  = out_index == IDX_W'(NUM_BEATS - 1);
   assign beat      = act_v & out_ready;
   assign fin       = beat & out_last;
   assign drop      = in_valid & pend_v;
   // later assignments take priority: shift, then word completion, then new arrival
   always_comb begin
      act_n    = act;
      act_v_n  = act_v;
      pend_n   = pend;
      pend_v_n = pend_v;
      idx_n    = out_index;
      if (beat & ~out_last) begin
         act_n = act >> BEAT_WIDTH;
         idx_n = out_index + 1'b1;
      end
      if (fin) begin
         act_n    = pend;
         act_v_n  = pend_v;
         pend_v_n = 1'b0;
         idx_n    = '0;
      end
      if (in_valid & ~pend_v) begin
         if (~act_v | fin) begin
            act_n   = in_data;
            act_v_n = 1'b1;
            idx_n   = '0;
         end else begin
            pend_n   = in_data;
            pend_v_n = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         act       <= '0;
         pend      <= '0;
         act_v     <= 1'b0;
         pend_v    <= 1'b0;
         out_index <= '0;
         drop_cnt  <= '0;
         overflow  <= 1'b0;
      end else begin
         act       <= act_n;
         pend      <= pend_n;
         act_v     <= act_v_n;
         pend_v    <= pend_v_n;
         out_index <= idx_n;
         if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
         overflow  <= overflow | drop;
      end
   end
endmodule

// File: doc/adder_421_result_unloader.md
Name: adder_421_result_unloader

Overview:
- Output-side companion to the 4-to-1 pipelined adder.
- Captures each wide sum word S presented with the adder's out_valid.
- Streams the word out as BEAT_WIDTH-bit beats, LSB beat first, over a valid/ready interface, so results can be drained through a narrow port instead of truncated.
- Two-entry buffering (active shift register plus one pending word) hides one word of back-to-back adder output.
- The adder cannot be stalled. Words that arrive with no buffer space are dropped and counted.

Parameters:
- IN_WIDTH, 1024, width of the captured sum word; must be an integer multiple of BEAT_WIDTH.
- BEAT_WIDTH, 128, output beat width.
- NUM_BEATS, IN_WIDTH/BEAT_WIDTH (derived, localparam), beats per word; must be ≥2.
- CNT_WIDTH, 16, width of the drop counter.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- resetn, input, 1, asynchronous active-low reset.
- in_valid, input, 1, sum word valid (from adder out_valid).
- in_data, input, IN_WIDTH, sum word (from adder S).
- in_ready, output, 1, a word presented now will be stored.
- out_valid, output, 1, beat valid.
- out_ready, input, 1, downstream accepts beat.
- out_data, output, BEAT_WIDTH, current beat = active[BEAT_WIDTH-1:0].
- out_last, output, 1, current beat is beat NUM_BEATS-1 of its word.
- out_index, output, clog2(NUM_BEATS), beat number within word.
- drop_cnt, output, CNT_WIDTH, saturating count of dropped words.
- overflow, output, 1, sticky; set on first drop, cleared only by reset.

Behaviour:
- Reset (async, resetn=0) forces:
  - act_v=0, pend_v=0, out_index=0, drop_cnt=0, overflow=0.
  - out_valid=0, out_last=0, in_ready=1.
  - Data registers may also clear to 0.
  - Reset mid-word discards the active and pending words with no further beats emitted.
- Beat handshake: a beat transfers when out_valid & out_ready. Define fin = out_valid & out_ready & out_last.
- Output stability: out_valid=act_v. While out_valid=1 and out_ready=0, out_data, out_index and out_last hold stable.
- Beat advance: on a non-final handshake, the active register shifts right by BEAT_WIDTH and out_index increments.
- out_last = (out_index==NUM_BEATS-1).
- Ready rule: in_ready = ~pend_v, registered-state only. There is no combinational path from out_ready to in_ready.
- Load rules, evaluated per cycle:
  - pend_v=0, act_v=0, in_valid: in_data -> active; act_v=1; out_index=0.
  - pend_v=0, act_v=1, ~fin, in_valid: in_data -> pending; pend_v=1.
  - pend_v=0, fin, in_valid: in_data -> active directly; out_index=0; act_v stays 1. No bubble.
  - pend_v=0, fin, ~in_valid: act_v=0.
  - pend_v=1, fin: pending -> active; pend_v=0; out_index=0. If in_valid in the same cycle, that word is dropped (in_ready was 0).
  - pend_v=1, ~fin, in_valid: drop.
- Drop: drop_cnt increments by 1, saturating at all-ones; overflow=1.
- Latency: word accepted at edge t -> beat 0 has out_valid=1 after edge t. The last beat can complete at edge t+NUM_BEATS with out_ready held high.
- Throughput: with out_ready=1, one word per NUM_BEATS cycles, continuous out_valid. Input rate of one word every NUM_BEATS cycles is loss-free indefinitely.
- Ordering: words emerge in arrival order; beats of a word never interleave.
- Data: out_data bits are an exact slice of the captured word; no arithmetic or sign handling.

Test Plan:
- Single word, IN_WIDTH=1024, beats k=0..7 = 128'h{k+1} repeated pattern, out_ready=1:
  - out_valid rises one cycle after capture.
  - out_data sequence 1,2,…,8.
  - out_last only on index 7.
  - out_valid falls after 8 beats.
- Backpressure, same word, out_ready toggling 1,0,0,1,…:
  - Every beat emitted exactly once, in order.
  - out_data, out_index and out_last stable during each stall.
- Two words W0 and W1 one cycle apart, out_ready=1:
  - W1 goes to pending; in_ready=0 for 7 cycles.
  - After W0's beat 7, W1 beat 0 follows on the next cycle with no gap.
  - drop_cnt=0.
- Third word W2 while pend_v=1, including a W2 arrival in the same cycle as W0's final beat:
  - W2 dropped; drop_cnt=1; overflow=1.
  - Output shows only W0 then W1.
- Steady input every 8 cycles for 100 words, out_ready=1:
  - 800 beats, all matching.
  - out_valid never drops once started.
  - drop_cnt=0.
- resetn pulsed low mid-word (after beat 3 accepted), with a word pending:
  - Immediately out_valid=0, in_ready=1, drop_cnt=0.
  - After release, a new word streams correctly from index 0.
